diff_sub_pipe: RTL and testbench

- Pipelined first-difference block: y[n] = x[n] − x[n−1]. It is the inverse of an accumulator/integrator.
- Each valid sample is interpreted as signed (two's complement) or unsigned, selected per sample.
- Each result is either wrapped or saturated, and carries an overflow flag.
- Used in the filter datapath as the comb/differentiator stage that follows integrator sections.
- Also serves as the test vehicle for signed vs unsigned subtraction.

---
 rtl/diff_sub_pipe_if.sv | 24 ++
 rtl/diff_sub_pipe.sv | 99 +++++++++
 tb/tb_diff_sub_pipe.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/diff_sub_pipe_if.sv
// Sample/result bundle for the first-difference pipeline.
// The master drives samples and control; the slave (the datapath) returns results.
interface diff_sub_pipe_if #(
    parameter int W = 4
);
    logic         clr;
    logic         din_valid;
    logic [W-1:0] din;
    logic         sign_mode;
    logic         sat_en;
    logic         dout_valid;
    logic [W-1:0] dout;
    logic         ovf;

    modport master (
        output clr, din_valid, din, sign_mode, sat_en,
        input  dout_valid, dout, ovf
    );

    modport slave (
        input  clr, din_valid, din, sign_mode, sat_en,
        output dout_valid, dout, ovf
    );
endinterface

// File: rtl/diff_sub_pipe.sv
// Two-stage first-difference pipeline: y[n] = x[n] - x[n-1].
// Stage 1 forms a (W+1)-bit difference; stage 2 detects overflow and wraps or clamps.
// Control is a plain valid shift chain; the history holds raw input bits.
module diff_sub_pipe #(
    parameter int W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    diff_sub_pipe_if.slave   bus
);

    logic [W-1:0] hist;
    logic [W-1:0] base;
    logic [W:0]   din_ext;
    logic [W:0]   base_ext;

    logic         s1_valid;
    logic [W:0]   s1_diff;
    logic         s1_sign;
    logic         s1_sat;

    logic         s2_ovf;
    logic [W-1:0] s2_res;

    logic [W-1:0] sat_pos;
    logic [W-1:0] sat_neg;

    // Extend the incoming sample and its differencing base per the sample's mode;
    // a clear alongside a sample makes that sample difference against zero.
    always_comb begin
        base     = bus.clr ? '0 : hist;
        din_ext  = bus.sign_mode ? {bus.din[W-1], bus.din} : {1'b0, bus.din};
        base_ext = bus.sign_mode ? {base[W-1], base} : {1'b0, base};
    end

    // History register: captures every valid sample, cleared by clr when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist <= '0;
        end else if (bus.din_valid) begin
            hist <= bus.din;
        end else if (bus.clr) begin
            hist <= '0;
        end
    end

    // Stage 1: register the full-precision difference and the sample's modes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_diff  <= '0;
            s1_sign  <= 1'b0;
            s1_sat   <= 1'b0;
        end else begin
            s1_valid <= bus.din_valid;
            if (bus.din_valid) begin
                s1_diff <= din_ext - base_ext;
                s1_sign <= bus.sign_mode;
                s1_sat  <= bus.sat_en;
            end
        end
    end

    // Overflow detection and wrap/saturate selection for the stage-1 difference.
    always_comb begin
        sat_pos = {1'b0, {(W-1){1'b1}}};
        sat_neg = {1'b1, {(W-1){1'b0}}};
        s2_res  = s1_diff[W-1:0];
        if (s1_sign) begin
            // Signed result fits iff the extra top bit agrees with the W-bit sign.
            s2_ovf = s1_diff[W] ^ s1_diff[W-1];
            if (s1_sat && s2_ovf) begin
                s2_res = s1_diff[W] ? sat_neg : sat_pos;
            end
        end else begin
            // Unsigned difference overflows only by borrowing below zero.
            s2_ovf = s1_diff[W];
            if (s1_sat && s2_ovf) begin
                s2_res = '0;
            end
        end
    end

    // Stage 2: publish result; dout/ovf hold their value between results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.dout_valid <= 1'b0;
            bus.dout       <= '0;
            bus.ovf        <= 1'b0;
        end else begin
            bus.dout_valid <= s1_valid;
            if (s1_valid) begin
                bus.dout <= s2_res;
                bus.ovf  <= s2_ovf;
            end
        end
    end

endmodule

// File: tb/tb_diff_sub_pipe.sv
// Self-checking bench for diff_sub_pipe: directed scenarios plus random traffic,
// compared against an integer-arithmetic reference model.
module tb_diff_sub_pipe;

    localparam int W    = 4;
    localparam int MAXS = (1 << (W - 1)) - 1;
    localparam int MINS = -(1 << (W - 1));
    localparam int MODV = 1 << W;

    logic clk;
    logic rst_n;

    diff_sub_pipe_if #(.W(W)) ifc ();

    diff_sub_pipe #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int m_hist;
    bit p_v;         // sample accepted on the previous edge
    int p_res;
    bit p_ovf;
    int last_res;
    bit last_ovf;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int as_val(input int raw, input bit sm);
        if (sm && raw >= (MODV / 2)) return raw - MODV;
        return raw;
    endfunction

    function automatic void model_diff(input int x, input int h, input bit sm, input bit sat,
                                       output int res, output bit ovf);
        int d;
        d = as_val(x, sm) - as_val(h, sm);
        if (sm) ovf = (d > MAXS) || (d < MINS);
        else    ovf = (d < 0);
        if (sat && ovf) begin
            if (sm) res = (d > 0) ? (MAXS & (MODV - 1)) : (MINS & (MODV - 1));
            else    res = 0;
        end else begin
            res = ((d % MODV) + MODV) % MODV;
        end
    endfunction

    task automatic model_reset();
        m_hist   = 0;
        p_v      = 1'b0;
        p_res    = 0;
        p_ovf    = 1'b0;
        last_res = 0;
        last_ovf = 1'b0;
    endtask

    // One clock cycle: drive at the negedge, model the edge, check at next negedge.
    task automatic step(input bit v, input int x, input bit sm, input bit sat, input bit c);
        bit exp_v;
        int r;
        bit o;
        ifc.din_valid = v;
        ifc.din       = x[W-1:0];
        ifc.sign_mode = sm;
        ifc.sat_en    = sat;
        ifc.clr       = c;
        @(posedge clk);
        exp_v = p_v;
        if (p_v) begin
            last_res = p_res;
            last_ovf = p_ovf;
        end
        p_v = v;
        if (v) begin
            model_diff(x, c ? 0 : m_hist, sm, sat, r, o);
            p_res  = r;
            p_ovf  = o;
            m_hist = x;
        end else if (c) begin
            m_hist = 0;
        end
        @(negedge clk);
        check("dout_valid", int'(ifc.dout_valid), int'(exp_v));
        check("dout", int'(ifc.dout), last_res);
        check("ovf", int'(ifc.ovf), int'(last_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic async_reset();
        rst_n = 1'b0;
        #2;
        model_reset();
        check("rst_valid", int'(ifc.dout_valid), 0);
        check("rst_dout", int'(ifc.dout), 0);
        check("rst_ovf", int'(ifc.ovf), 0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        rst_n         = 1'b0;
        ifc.clr       = 1'b0;
        ifc.din_valid = 1'b0;
        ifc.din       = '0;
        ifc.sign_mode = 1'b0;
        ifc.sat_en    = 1'b0;
        @(negedge clk);
        check("reset_valid", int'(ifc.dout_valid), 0);
        check("reset_dout", int'(ifc.dout), 0);
        check("reset_ovf", int'(ifc.ovf), 0);
        rst_n = 1'b1;
        idle(1);

        // Unsigned ramp, wrap: 3,5,9,15 -> 3,2,4,6
        step(1, 3, 0, 0, 0); step(1, 5, 0, 0, 0);
        step(1, 9, 0, 0, 0); step(1, 15, 0, 0, 0);
        idle(3);

        // Unsigned borrow with history 9, wrap then saturate
        step(1, 9, 0, 0, 0); step(1, 4, 0, 0, 0);
        step(1, 9, 0, 0, 0); step(1, 4, 0, 1, 0);
        idle(3);

        // Signed overflow around -8 / 7
        step(1, 8, 1, 0, 0); step(1, 7, 1, 1, 0);
        step(1, 8, 1, 0, 0); step(1, 7, 1, 0, 0);
        step(1, 8, 1, 1, 0);
        idle(3);

        // Clear with and without a sample
        step(1, 6, 0, 0, 0); step(1, 5, 0, 0, 1); step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 1); step(1, 4, 0, 0, 0);
        idle(3);

        // Reset mid-stream discards in-flight samples
        step(1, 7, 0, 0, 0); step(1, 11, 0, 0, 0);
        async_reset();
        idle(4);
        step(1, 2, 0, 0, 0);
        idle(3);

        // Gapped sample with mode switch: signed 0xF, gap, unsigned 0xF
        async_reset();
        step(1, 15, 1, 0, 0);
        idle(5);
        step(1, 15, 0, 0, 0);
        idle(3);

        // Random traffic with occasional resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) async_reset();
            step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, MODV - 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 9) == 0));
        end
        idle(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
